ram_dp_be: RTL and testbench
============================

Name: ram_dp_be

Overview:
Simple dual-port synchronous RAM with one write port and one read port, the parametrised successor to the team's basic dual-port RAM. Adds per-byte write enables, selectable read latency (1 or 2), a selectable read-during-write collision mode, a read-valid strobe, and a post-reset memory-clear state machine. Used as the storage primitive under FIFOs and buffers that need known-clean contents after reset.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8; NB = WIDTH/8 byte lanes
DEPTH, 16, number of words; need not be a power of 2; AW = max(1, $clog2(DEPTH))
RD_LATENCY, 1, edges from rdEn sample to rddata/rdValid update; legal values 1 or 2
WRITE_FIRST, 0, 1 = collision read returns newly written bytes; 0 = collision read returns old contents
INIT_VALUE, 0, WIDTH-bit value written to every word by the clear FSM

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
wrEn  input  1  write request
wrBe  input  NB  byte enables; bit i covers wrdata[8i+7:8i]
wraddr  input  AW  write address
wrdata  input  WIDTH  write data
rdEn  input  1  read request
rdaddr  input  AW  read address
rddata  output  WIDTH  read data, registered
rdValid  output  1  one-cycle strobe; rddata is valid for the read it marks
initBusy  output  1  high while the clear FSM runs; requests are ignored while high

Behaviour:
- Reset (rst_n low, asynchronous): rddata=0, rdValid=0, initBusy=1, clear counter=0, all read pipeline stages invalid, FSM=INIT. Memory array has no async reset.
- FSM INIT: on each rising edge, write INIT_VALUE to mem[cnt] and increment cnt. The edge that writes DEPTH-1 moves the FSM to RUN and drops initBusy to 0. The clear takes exactly DEPTH edges after rst_n rises.
- INIT: wrEn/rdEn ignored; no user writes; no rdValid.
- FSM RUN: stays in RUN until reset.
- Write: when wrEn=1, for each i with wrBe[i]=1, byte i of mem[wraddr] <= wrdata byte i. wrEn=1 with wrBe=0 changes nothing.
- Read: rdEn=1 sampled at edge N.
  - RD_LATENCY=1: rddata and rdValid update at edge N.
  - RD_LATENCY=2: rddata and rdValid update at edge N+1.
  - rdValid is high for exactly one cycle per accepted read.
  - Back-to-back reads give one strobe per cycle.
  - rddata holds its last value while rdValid=0.
- Collision (wrEn & rdEn & wraddr==rdaddr, same edge):
  - WRITE_FIRST=1: the returned word has wrdata bytes where wrBe=1 and old bytes elsewhere.
  - WRITE_FIRST=0: the whole word is the old contents.
- Out-of-range address (>= DEPTH, non-power-of-2 depth only):
  - Write is dropped.
  - Read returns 0 with rdValid=1.
- Simultaneous write and read to different addresses are fully independent.
- Reset mid-operation: in-flight reads are discarded (rdValid stays 0), the FSM returns to INIT, and the full clear repeats.

Optional Feature:
RAM_PARITY_EN
- Defined:
  - Stores one even-parity bit per byte alongside the data; the clear FSM writes correct parity for INIT_VALUE.
  - Extra input wrParInv (NB bits): when set for a written byte, the stored parity bit is inverted (error injection).
  - Extra output rdParErr (NB bits) is registered and aligned with rdValid; bit i=1 when byte i fails parity. It is 0 whenever rdValid=0 and 0 on reset.
  - Parity is checked on the stored data (old data on a WRITE_FIRST=0 collision). Merged bytes on a WRITE_FIRST=1 collision take their parity from the incoming write.
- Undefined: no parity storage; wrParInv and rdParErr ports do not exist.

Test Plan:
- Clear: WIDTH=32, DEPTH=16, INIT_VALUE=32'hA5A5A5A5; release rst_n -> initBusy high for exactly 16 edges; then reads of addr 0..15 all return A5A5A5A5 with rdValid.
- Byte enables: write 32'h11223344 to addr 3 with wrBe=4'hF, then 32'hAABBCCDD with wrBe=4'b0101; read addr 3 -> 32'h11BB33DD.
- Latency: RD_LATENCY=2, rdEn pulses at edges 5,6,7 -> rdValid high after edges 6,7,8 with the matching data; RD_LATENCY=1 -> after edges 5,6,7.
- Collision: addr 2 holds 32'h0, then same-edge write 32'hFFFFFFFF (wrBe=4'b0011) and read of addr 2 -> WRITE_FIRST=1 returns 32'h0000FFFF; WRITE_FIRST=0 returns 32'h00000000.
- Reset mid-read and during INIT: assert rst_n low one cycle after rdEn -> no rdValid; FSM re-clears all DEPTH words; requests made during initBusy are ignored.
- Parity (RAM_PARITY_EN): write addr 5 with wrParInv=4'b1000, then read -> rdParErr=4'b1000 with rdValid; read an unmodified address -> rdParErr=0.

Source files
------------

// File: rtl/ram_dp_be.sv
// rtl/ram_dp_be.sv - simple dual-port RAM, byte enables, post-reset clear FSM, selectable read latency
// Optional parity storage and checking is enabled by defining RAM_PARITY_EN.
module ram_dp_be #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 16,
    parameter int               RD_LATENCY  = 1,
    parameter int               WRITE_FIRST = 0,
    parameter logic [WIDTH-1:0] INIT_VALUE  = '0,
    localparam int              NB          = WIDTH / 8,
    localparam int              AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrEn,
    input  logic [NB-1:0]    wrBe,
    input  logic [AW-1:0]    wraddr,
    input  logic [WIDTH-1:0] wrdata,
    input  logic             rdEn,
    input  logic [AW-1:0]    rdaddr,
    output logic [WIDTH-1:0] rddata,
    output logic             rdValid,
    output logic             initBusy
`ifdef RAM_PARITY_EN
    ,
    input  logic [NB-1:0]    wrParInv,
    output logic [NB-1:0]    rdParErr
`endif
);

    localparam bit            FULL_RANGE = (DEPTH == (1 << AW));
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            wr_in, rd_in;
    logic            wr_go, rd_go, collide;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        end
    end

    assign initBusy = (state_q == S_INIT);

    // Addresses can only fall outside the array when DEPTH is not a power of two.
    generate
        if (FULL_RANGE) begin : g_full
            assign wr_in = 1'b1;
            assign rd_in = 1'b1;
        end else begin : g_part
            assign wr_in = (wraddr < AW'(DEPTH));
            assign rd_in = (rdaddr < AW'(DEPTH));
        end
    endgenerate

    assign wr_go   = wrEn && (state_q == S_RUN) && wr_in;
    assign rd_go   = rdEn && (state_q == S_RUN);
    assign collide = wr_go && (wraddr == rdaddr);

`ifdef RAM_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];
    logic [NB-1:0] rd_err;

    function automatic logic [NB-1:0] byte_par(input logic [WIDTH-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem[cnt_q] <= INIT_VALUE;
`ifdef RAM_PARITY_EN
            mem_par[cnt_q] <= byte_par(INIT_VALUE);
`endif
        end else if (wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (wrBe[i]) begin
                    mem[wraddr][8*i +: 8] <= wrdata[8*i +: 8];
`ifdef RAM_PARITY_EN
                    mem_par[wraddr][i] <= (^wrdata[8*i +: 8]) ^ wrParInv[i];
`endif
                end
            end
        end
    end

    // Merged bytes on a write-first collision carry the parity the write would have stored.
    always_comb begin
        rd_word = '0;
`ifdef RAM_PARITY_EN
        rd_err  = '0;
`endif
        if (rd_in) begin
            rd_word = mem[rdaddr];
`ifdef RAM_PARITY_EN
            rd_err  = byte_par(mem[rdaddr]) ^ mem_par[rdaddr];
`endif
            if ((WRITE_FIRST != 0) && collide) begin
                for (int i = 0; i < NB; i++) begin
                    if (wrBe[i]) begin
                        rd_word[8*i +: 8] = wrdata[8*i +: 8];
`ifdef RAM_PARITY_EN
                        rd_err[i] = wrParInv[i];
`endif
                    end
                end
            end
        end
    end

`ifdef RAM_PARITY_EN
    localparam int PL = WIDTH + NB;
    logic [PL-1:0] rd_pay;
    assign rd_pay = {rd_err, rd_word};
`else
    localparam int PL = WIDTH;
    logic [PL-1:0] rd_pay;
    assign rd_pay = rd_word;
`endif

    logic          st_valid;
    logic [PL-1:0] st_pay;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic          s1_valid;
            logic [PL-1:0] s1_pay;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1_pay   <= '0;
                end else begin
                    s1_valid <= rd_go;
                    if (rd_go) begin
                        s1_pay <= rd_pay;
                    end
                end
            end
            assign st_valid = s1_valid;
            assign st_pay   = s1_pay;
        end else begin : g_lat1
            assign st_valid = rd_go;
            assign st_pay   = rd_pay;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rddata  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= st_valid;
            if (st_valid) begin
                rddata <= st_pay[WIDTH-1:0];
            end
        end
    end

`ifdef RAM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdParErr <= '0;
        end else begin
            rdParErr <= st_valid ? st_pay[PL-1:WIDTH] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_ram_dp_be.sv
// tb/tb_ram_dp_be.sv - scoreboard bench for ram_dp_be over three latency/collision/depth configurations
module tb_ram_dp_be;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  par;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrEn = 1'b0;
    logic [3:0]  wrBe = '0;
    logic [3:0]  wraddr = '0;
    logic [31:0] wrdata = '0;
    logic        rdEn = 1'b0;
    logic [3:0]  rdaddr = '0;
    logic [3:0]  par_inv = '0;

    logic [31:0] rdd  [3];
    logic        vld  [3];
    logic        busy [3];
`ifdef RAM_PARITY_EN
    logic [3:0]  pe   [3];
`endif

    exp_t        sb [3][$];
    logic [31:0] last [3] = '{32'h0, 32'h0, 32'h0};
    int          lat  [3] = '{1, 2, 1};
    int          clr  [3] = '{16, 16, 12};
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // dut0: latency 1 read-first; dut1: latency 2 write-first; dut2: depth 12 write-first
    for (genvar k = 0; k < 3; k++) begin : g_dut
        ram_dp_be #(
            .WIDTH(32),
            .DEPTH((k == 2) ? 12 : 16),
            .RD_LATENCY((k == 1) ? 2 : 1),
            .WRITE_FIRST((k == 0) ? 0 : 1),
            .INIT_VALUE(IV)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .wrEn(wrEn),
            .wrBe(wrBe),
            .wraddr(wraddr),
            .wrdata(wrdata),
            .rdEn(rdEn),
            .rdaddr(rdaddr),
            .rddata(rdd[k]),
            .rdValid(vld[k]),
            .initBusy(busy[k])
`ifdef RAM_PARITY_EN
            ,
            .wrParInv(par_inv),
            .rdParErr(pe[k])
`endif
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) last[k] = '0;
            checks++;
            if (vld[k]) begin
                if (sb[k].size() == 0) begin
                    errors++;
                    $display("FAIL strobe dut%0d unexpected rdValid data=%h edge=%0d", k, rdd[k], cyc);
                end else begin
                    mon_e = sb[k].pop_front();
                    if (rdd[k] !== mon_e.data || cyc != mon_e.cyc
`ifdef RAM_PARITY_EN
                        || pe[k] !== mon_e.par
`endif
                    ) begin
                        errors++;
                        $display("FAIL read dut%0d got data=%h edge=%0d want data=%h edge=%0d par_want=%b",
                                 k, rdd[k], cyc, mon_e.data, mon_e.cyc, mon_e.par);
                    end
                end
                last[k] = rdd[k];
            end else begin
                if (rdd[k] !== last[k]
`ifdef RAM_PARITY_EN
                    || pe[k] !== 4'h0
`endif
                ) begin
                    errors++;
                    $display("FAIL hold dut%0d got data=%h want data=%h", k, rdd[k], last[k]);
                end
            end
        end
    end

    task automatic op(input logic we, input logic [3:0] be, input logic [3:0] wa,
                      input logic [31:0] wd, input logic [3:0] pinv, input logic re,
                      input logic [3:0] ra, input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [3:0] ep);
        exp_t x;
        @(negedge clk);
        #1;
        wrEn = we; wrBe = be; wraddr = wa; wrdata = wd; par_inv = pinv;
        rdEn = re; rdaddr = ra;
        if (re) begin
            for (int k = 0; k < 3; k++) begin
                x.data = (k == 0) ? e0 : ((k == 1) ? e1 : e2);
                x.par  = ep;
                x.cyc  = cyc + lat[k];
                sb[k].push_back(x);
            end
        end
    endtask

    task automatic idle();
        op(1'b0, 4'h0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic rd(input logic [3:0] ra, input logic [31:0] e);
        op(1'b0, 4'h0, 4'd0, 32'h0, 4'h0, 1'b1, ra, e, e, e, 4'h0);
    endtask

    task automatic wr(input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be);
        op(1'b1, be, wa, wd, 4'h0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 4'h0);
    endtask

    // Counts edges from reset release until each initBusy drops; requests end once any DUT is running.
    task automatic wait_clear();
        int n [3] = '{0, 0, 0};
        int t = 0;
        while ((busy[0] || busy[1] || busy[2]) && t < 100) begin
            @(negedge clk);
            t++;
            for (int k = 0; k < 3; k++) begin
                if (!busy[k] && n[k] == 0) n[k] = t;
            end
            if (!busy[0] || !busy[1] || !busy[2]) begin
                wrEn = 1'b0;
                rdEn = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (n[k] != clr[k]) begin
                errors++;
                $display("FAIL clear_len dut%0d got %0d edges want %0d", k, n[k], clr[k]);
            end
        end
        #1;
        wrEn = 1'b0;
        rdEn = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdd[k] !== 32'h0 || vld[k] !== 1'b0 || busy[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset dut%0d got data=%h valid=%b busy=%b want 0/0/1", k, rdd[k], vld[k], busy[k]);
            end
        end

        #1;
        rst_n = 1'b1;
        wrEn = 1'b1; wrBe = 4'hF; wraddr = 4'd7; wrdata = 32'hDEADBEEF;
        rdEn = 1'b1; rdaddr = 4'd7;
        wait_clear();

        for (int a = 0; a < 16; a++) begin
            op(1'b0, 4'h0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(a), IV, IV, (a < 12) ? IV : 32'h0, 4'h0);
        end

        wr(4'd3, 32'h11223344, 4'hF);
        wr(4'd3, 32'hAABBCCDD, 4'b0101);
        op(1'b1, 4'h0, 4'd4, 32'h12345678, 4'h0, 1'b1, 4'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 4'h0);
        rd(4'd4, IV);

        wr(4'd2, 32'h0, 4'hF);
        op(1'b1, 4'b0011, 4'd2, 32'hFFFFFFFF, 4'h0, 1'b1, 4'd2, 32'h0, 32'h0000FFFF, 32'h0000FFFF, 4'h0);
        rd(4'd2, 32'h0000FFFF);

        op(1'b1, 4'hF, 4'd9, 32'h01020304, 4'h0, 1'b1, 4'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 4'h0);
        rd(4'd9, 32'h01020304);

        wr(4'd14, 32'h77777777, 4'hF);
        op(1'b0, 4'h0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd14, 32'h77777777, 32'h77777777, 32'h0, 4'h0);

`ifdef RAM_PARITY_EN
        op(1'b1, 4'hF, 4'd5, 32'h5555AAAA, 4'b1000, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 4'h0);
        op(1'b0, 4'h0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5, 32'h5555AAAA, 32'h5555AAAA, 32'h5555AAAA, 4'b1000);
        rd(4'd6, IV);
`endif

        // Read in flight on the latency-2 DUT is cancelled by reset.
        rd(4'd3, 32'h11BB33DD);
        void'(sb[1].pop_back());
        @(negedge clk);
        #1;
        rdEn = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        wait_clear();

        rd(4'd3, IV);
        rd(4'd9, IV);
        op(1'b0, 4'h0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd14, IV, IV, 32'h0, 4'h0);
        rd(4'd2, IV);

        repeat (4) idle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sb[k].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d got %0d reads outstanding want 0", k, sb[k].size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
